branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor for the RISC-V core: a direct-mapped branch target buffer whose entries each hold a 2-bit saturating direction counter. Fetch looks up the current PC combinationally and receives a predicted next PC. Execute writes back the resolved outcome of every B-type instruction: the `branch_taken` result of the branch comparator, plus the computed target. The block also flags a mispredict so fetch can redirect.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of the branch predictor: lookup, resolution,
// flush and statistics.
interface branch_predictor_if;
   logic [31:0] pc_f;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        upd_valid;
   logic        upd_is_b_type;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_pc;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        bp_flush;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   modport master (
      output pc_f, upd_valid, upd_is_b_type, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_pc, bp_flush,
      input  pred_taken, pred_pc, mispredict, redirect_pc, stat_branches, stat_mispredicts
   );

   modport slave (
      input  pc_f, upd_valid, upd_is_b_type, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_pc, bp_flush,
      output pred_taken, pred_pc, mispredict, redirect_pc, stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup, updates visible next cycle, no backpressure.
// Optional performance counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input logic               clk,
   input logic               reset,
   branch_predictor_if.slave bp
);
   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = 30 - IDX;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAGW-1:0]    tag_q    [ENTRIES];
   logic [TAGW-1:0]    tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];

   logic [IDX-1:0]  f_idx, u_idx;
   logic [TAGW-1:0] f_tag, u_tag;
   logic            f_hit, u_hit, upd_act;

   assign f_idx = bp.pc_f[IDX+1:2];
   assign f_tag = bp.pc_f[31:IDX+2];
   assign u_idx = bp.upd_pc[IDX+1:2];
   assign u_tag = bp.upd_pc[31:IDX+2];

   assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign upd_act = bp.upd_valid && bp.upd_is_b_type;

   assign bp.pred_taken  = f_hit && ctr_q[f_idx][1];
   assign bp.pred_pc     = bp.pred_taken ? target_q[f_idx] : bp.pc_f + 32'd4;
   assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
   assign bp.mispredict  = upd_act && (bp.upd_pred_pc != bp.redirect_pc);

   // Only the carried pred_pc matters for the mispredict decision; low PC bits are ignored.
   logic unused_ok;
   assign unused_ok = ^{bp.upd_pred_taken, bp.pc_f[1:0], bp.upd_pc[1:0]};

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (bp.bp_flush) begin
         valid_d = '0;
      end else if (upd_act) begin
         if (u_hit) begin
            if (bp.upd_taken) begin
               ctr_d[u_idx]    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
               target_d[u_idx] = bp.upd_target;
            end else begin
               ctr_d[u_idx] = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
            end
         end else if (bp.upd_taken) begin
            valid_d[u_idx]  = 1'b1;
            tag_d[u_idx]    = u_tag;
            target_d[u_idx] = bp.upd_target;
            ctr_d[u_idx]    = 2'b10;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   // Payload is meaningless while its valid bit is clear, so it carries no reset.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
   end

`ifdef BP_STATS_EN
   logic [31:0] stat_br_q, stat_mp_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else if (upd_act) begin
         stat_br_q <= stat_br_q + 32'd1;
         if (bp.mispredict) stat_mp_q <= stat_mp_q + 32'd1;
      end
   end

   assign bp.stat_branches    = stat_br_q;
   assign bp.stat_mispredicts = stat_mp_q;
`else
   assign bp.stat_branches    = '0;
   assign bp.stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, counter walk, aliasing, flush,
// reset and statistics.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

`ifdef BP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   branch_predictor_if bp_if ();

   branch_predictor #(.ENTRIES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bp_if)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%0b exp=%0b", name, got, exp);
      else n_pass++;
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
      else n_pass++;
   endtask

   task automatic upd(input logic b, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic [31:0] ppc);
      bp_if.upd_valid      = 1'b1;
      bp_if.upd_is_b_type  = b;
      bp_if.upd_pc         = pc;
      bp_if.upd_taken      = tk;
      bp_if.upd_target     = tgt;
      bp_if.upd_pred_pc    = ppc;
      bp_if.upd_pred_taken = (ppc != pc + 32'd4);
   endtask

   task automatic idle();
      bp_if.upd_valid     = 1'b0;
      bp_if.upd_is_b_type = 1'b0;
      bp_if.bp_flush      = 1'b0;
   endtask

   // Inputs change on the falling edge; the rising edge in between captures them.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic lookup(input logic [31:0] pc);
      bp_if.pc_f = pc;
      #1;
   endtask

   task automatic test_reset();
      idle();
      bp_if.pc_f = 32'h0; bp_if.upd_pc = 32'h0; bp_if.upd_taken = 1'b0;
      bp_if.upd_target = 32'h0; bp_if.upd_pred_pc = 32'h0; bp_if.upd_pred_taken = 1'b0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      lookup(32'h100);
      chk1 ("rst_pred_taken", bp_if.pred_taken, 1'b0);
      chk32("rst_pred_pc",    bp_if.pred_pc,    32'h104);
      chk1 ("rst_mispredict", bp_if.mispredict, 1'b0);
      chk32("rst_stat_br",    bp_if.stat_branches, 32'h0);
      lookup(32'hFFFF_FFFC);
      chk32("pc4_wrap",       bp_if.pred_pc,    32'h0);
   endtask

   task automatic test_alloc();
      tick();
      upd(1'b1, 32'h100, 1'b1, 32'h80, 32'h104);
      lookup(32'h100);
      chk1 ("alloc_mispredict", bp_if.mispredict,  1'b1);
      chk32("alloc_redirect",   bp_if.redirect_pc, 32'h80);
      chk1 ("alloc_no_bypass",  bp_if.pred_taken,  1'b0);
      tick(); idle(); #1;
      chk1 ("alloc_pred_taken", bp_if.pred_taken, 1'b1);
      chk32("alloc_pred_pc",    bp_if.pred_pc,    32'h80);
   endtask

   task automatic test_counter();
      // ctr 10 -> T:11 -> T:11 -> N:10 -> N:01 -> T:10 (with new target)
      upd(1'b1, 32'h100, 1'b1, 32'h80, 32'h80); #1;
      chk1("ctr_t1_mispredict", bp_if.mispredict, 1'b0);
      tick(); idle(); #1;
      chk32("ctr_t1_pred_pc", bp_if.pred_pc, 32'h80);
      upd(1'b1, 32'h100, 1'b1, 32'h80, 32'h80);
      tick(); idle(); #1;
      chk32("ctr_t2_pred_pc", bp_if.pred_pc, 32'h80);
      upd(1'b1, 32'h100, 1'b0, 32'h300, 32'h80); #1;
      chk1 ("ctr_n1_mispredict", bp_if.mispredict,  1'b1);
      chk32("ctr_n1_redirect",   bp_if.redirect_pc, 32'h104);
      tick(); idle(); #1;
      chk32("ctr_n1_pred_pc", bp_if.pred_pc, 32'h80);
      upd(1'b1, 32'h100, 1'b0, 32'h300, 32'h80);
      tick(); idle(); #1;
      chk1 ("ctr_n2_pred_taken", bp_if.pred_taken, 1'b0);
      chk32("ctr_n2_pred_pc",    bp_if.pred_pc,    32'h104);
      upd(1'b1, 32'h100, 1'b1, 32'h90, 32'h104); #1;
      chk1("ctr_t3_mispredict", bp_if.mispredict, 1'b1);
      tick(); idle(); #1;
      chk32("ctr_t3_new_target", bp_if.pred_pc, 32'h90);
   endtask

   task automatic test_alias();
      lookup(32'h140);
      chk1 ("alias_miss_taken", bp_if.pred_taken, 1'b0);
      chk32("alias_miss_pc",    bp_if.pred_pc,    32'h144);
      upd(1'b1, 32'h1C0, 1'b0, 32'h700, 32'h1C4); #1;
      chk1("miss_nt_mispredict", bp_if.mispredict, 1'b0);
      tick(); idle();
      lookup(32'h100);
      chk32("miss_nt_no_change", bp_if.pred_pc, 32'h90);
      upd(1'b1, 32'h140, 1'b1, 32'h200, 32'h144);
      tick(); idle();
      lookup(32'h140);
      chk32("alias_replace_pc", bp_if.pred_pc, 32'h200);
      lookup(32'h100);
      chk32("alias_evicted_pc", bp_if.pred_pc, 32'h104);
   endtask

   task automatic test_flush();
      upd(1'b0, 32'h180, 1'b1, 32'h500, 32'h184); #1;
      chk1("nonb_mispredict", bp_if.mispredict, 1'b0);
      tick(); idle();
      lookup(32'h180);
      chk32("nonb_no_alloc", bp_if.pred_pc, 32'h184);
      upd(1'b1, 32'h180, 1'b1, 32'h500, 32'h184);
      bp_if.bp_flush = 1'b1;
      tick(); idle();
      lookup(32'h180);
      chk1 ("flush_drop_taken", bp_if.pred_taken, 1'b0);
      chk32("flush_drop_pc",    bp_if.pred_pc,    32'h184);
      lookup(32'h140);
      chk32("flush_clear_pc",   bp_if.pred_pc,    32'h144);
   endtask

   task automatic test_stats();
      reset = 1'b1; tick(); reset = 1'b0;
      upd(1'b1, 32'h10, 1'b1, 32'h40, 32'h40); tick();
      upd(1'b1, 32'h20, 1'b0, 32'h0,  32'h24); tick();
      upd(1'b1, 32'h30, 1'b1, 32'h50, 32'h34); tick();
      upd(1'b1, 32'h10, 1'b1, 32'h40, 32'h40); tick();
      upd(1'b1, 32'h20, 1'b0, 32'h0,  32'h90); tick();
      upd(1'b0, 32'h44, 1'b1, 32'h0,  32'h0);  tick();
      idle(); #1;
      chk32("stat_branches",    bp_if.stat_branches,    STATS ? 32'd5 : 32'd0);
      chk32("stat_mispredicts", bp_if.stat_mispredicts, STATS ? 32'd2 : 32'd0);
      bp_if.bp_flush = 1'b1; tick(); idle(); #1;
      chk32("stat_br_flush", bp_if.stat_branches,    STATS ? 32'd5 : 32'd0);
      chk32("stat_mp_flush", bp_if.stat_mispredicts, STATS ? 32'd2 : 32'd0);
      upd(1'b1, 32'h30, 1'b1, 32'h50, 32'h34);
      bp_if.bp_flush = 1'b1; tick(); idle(); #1;
      chk32("stat_br_flush_upd", bp_if.stat_branches,    STATS ? 32'd6 : 32'd0);
      chk32("stat_mp_flush_upd", bp_if.stat_mispredicts, STATS ? 32'd3 : 32'd0);
   endtask

   task automatic test_reset_midstream();
      upd(1'b1, 32'h10, 1'b1, 32'h40, 32'h14);
      reset = 1'b1; #1;
      chk1 ("rst_mid_mispredict", bp_if.mispredict,  1'b1);
      chk32("rst_mid_redirect",   bp_if.redirect_pc, 32'h40);
      tick(); reset = 1'b0; idle();
      lookup(32'h10);
      chk32("rst_mid_dropped", bp_if.pred_pc,          32'h14);
      chk32("rst_stat_br_clr", bp_if.stat_branches,    32'h0);
      chk32("rst_stat_mp_clr", bp_if.stat_mispredicts, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      test_reset();
      test_alloc();
      test_counter();
      test_alias();
      test_flush();
      test_stats();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
